// File: rtl/program_loader.sv
// Boot-time program loader: streams an image into memory while the CPU is held
// in halt, checksums it, and releases the CPU only when the sum matches.
module program_loader #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 16,
  parameter int LENGTH_WIDTH  = 16
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     START,
  input  logic [ADDRESS_WIDTH-1:0] LOAD_BASE,
  input  logic [LENGTH_WIDTH-1:0]  LOAD_LENGTH,
  input  logic [DATA_WIDTH-1:0]    EXPECTED_SUM,
  input  logic                     IN_VALID,
  input  logic [DATA_WIDTH-1:0]    IN_DATA,
  output logic                     IN_READY,
  output logic                     HALT,
  output logic                     MEM_WE,
  output logic [ADDRESS_WIDTH-1:0] ADDRESS_BUS,
  output logic [DATA_WIDTH-1:0]    DATA_OUT,
  output logic                     DATA_OE,
  output logic                     DONE,
  output logic                     ERROR
);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, RUN, FAULT} state_t;

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] base;
  logic [LENGTH_WIDTH-1:0]  length;
  logic [LENGTH_WIDTH-1:0]  count;
  logic [DATA_WIDTH-1:0]    expected;
  logic [DATA_WIDTH-1:0]    sum;
  logic [LENGTH_WIDTH-1:0]  count_inc;
  logic                     accept;

  assign count_inc = count + LENGTH_WIDTH'(1);
  assign accept    = (state == LOAD) && IN_VALID && IN_READY;

  // Writes are registered: a word accepted on one edge drives the memory bus
  // for the whole following cycle, and the bus is released in every other cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      base        <= '0;
      length      <= '0;
      count       <= '0;
      expected    <= '0;
      sum         <= '0;
      IN_READY    <= 1'b0;
      HALT        <= 1'b1;
      MEM_WE      <= 1'b0;
      DATA_OE     <= 1'b0;
      ADDRESS_BUS <= '0;
      DATA_OUT    <= '0;
      DONE        <= 1'b0;
      ERROR       <= 1'b0;
    end else begin
      MEM_WE      <= 1'b0;
      DATA_OE     <= 1'b0;
      ADDRESS_BUS <= '0;
      DATA_OUT    <= '0;
      case (state)
        IDLE, RUN, FAULT: begin
          if (START) begin
            base     <= LOAD_BASE;
            length   <= LOAD_LENGTH;
            expected <= EXPECTED_SUM;
            count    <= '0;
            sum      <= '0;
            HALT     <= 1'b1;
            DONE     <= 1'b0;
            ERROR    <= 1'b0;
            if (LOAD_LENGTH == '0) begin
              state    <= CHECK;
              IN_READY <= 1'b0;
            end else begin
              state    <= LOAD;
              IN_READY <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            MEM_WE      <= 1'b1;
            DATA_OE     <= 1'b1;
            ADDRESS_BUS <= base + ADDRESS_WIDTH'(count);
            DATA_OUT    <= IN_DATA;
            count       <= count_inc;
            sum         <= sum + IN_DATA;
            if (count_inc == length) begin
              state    <= CHECK;
              IN_READY <= 1'b0;
            end
          end
        end
        CHECK: begin
          // The final write drains during this cycle; the sum is already complete.
          if (sum == expected) begin
            state <= RUN;
            HALT  <= 1'b0;
            DONE  <= 1'b1;
          end else begin
            state <= FAULT;
            ERROR <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          IN_READY <= 1'b0;
          HALT     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, the memory word width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 16, the memory address width.
REQ-003 SHALL have parameter LENGTH_WIDTH, default 16, the width of the word-count input.
REQ-004 SHALL have ports: CLK in 1, single clock, all state on its rising edge.
REQ-005 SHALL have ports: RESET in 1, asynchronous, active-high.
REQ-006 SHALL have ports: START in 1, one-cycle load request.
REQ-007 SHALL have ports: LOAD_BASE in ADDRESS_WIDTH, first write address, sampled with START.
REQ-008 SHALL have ports: LOAD_LENGTH in LENGTH_WIDTH, number of words, sampled with START.
REQ-009 SHALL have ports: EXPECTED_SUM in DATA_WIDTH, image checksum, sampled with START.
REQ-010 SHALL have ports: IN_VALID in 1, IN_DATA in DATA_WIDTH, IN_READY out 1, the word stream.
REQ-011 SHALL have ports: HALT out 1, holds the CPU stopped.
REQ-012 SHALL have ports: MEM_WE out 1, ADDRESS_BUS out ADDRESS_WIDTH, DATA_OUT out DATA_WIDTH, DATA_OE out 1 (bus drive enable).
REQ-013 SHALL have ports: DONE out 1, load succeeded; ERROR out 1, checksum mismatch.

Function
REQ-014 SHALL implement states IDLE, LOAD, CHECK, RUN, FAULT.
REQ-015 IDLE: HALT=1; START moves to LOAD and latches base, length and expected sum; clears count and sum.
REQ-016 START with LOAD_LENGTH=0 SHALL go directly to CHECK with sum 0.
REQ-017 LOAD: IN_READY=1; a word is accepted on a rising edge with IN_VALID=1 and IN_READY=1.
REQ-018 An accepted word SHALL be written in the following cycle: MEM_WE=1, DATA_OE=1, ADDRESS_BUS=base+count, DATA_OUT=word.
REQ-019 Write throughput SHALL be one word per cycle, with no bubble under continuous IN_VALID.
REQ-020 In any cycle with no acceptance on the previous edge, MEM_WE SHALL be 0.
REQ-021 The address SHALL wrap modulo 2^ADDRESS_WIDTH.
REQ-022 The sum SHALL be the sum of accepted words modulo 2^DATA_WIDTH.
REQ-023 On the edge accepting word number LOAD_LENGTH, the FSM SHALL enter CHECK and IN_READY SHALL drop to 0.
REQ-024 CHECK SHALL last one cycle, during which the final write occurs.
REQ-025 On the CHECK exit edge, sum==expected SHALL go to RUN; a mismatch SHALL go to FAULT.
REQ-026 RUN: HALT=0, DONE=1, MEM_WE=0, DATA_OE=0, ADDRESS_BUS=0.
REQ-027 HALT SHALL fall exactly 2 edges after the final word is accepted.
REQ-028 FAULT: HALT=1, ERROR=1, DATA_OE=0, MEM_WE=0.
REQ-029 START SHALL be ignored in LOAD and CHECK.
REQ-030 START in RUN or FAULT SHALL enter LOAD, raising HALT and clearing DONE/ERROR on that edge.
REQ-031 DATA_OE SHALL equal MEM_WE in every cycle, so the bus is released whenever no write occurs.

Reset
REQ-032 While RESET=1 the block SHALL hold these values: state IDLE, HALT=1, MEM_WE=0, DATA_OE=0, ADDRESS_BUS=0, DATA_OUT=0, IN_READY=0, DONE=0, ERROR=0, count=0, sum=0.
REQ-033 RESET asserted mid-LOAD SHALL abandon the load immediately, including any pending write.
REQ-034 After RESET release, the block SHALL require a new START.

Verification
REQ-035 Nominal load: START base=0x0010 len=3 sum=0x0006, words 0x0000,0x0001,0x0005 back-to-back -> writes at 0x0010/0x0011/0x0012 on consecutive cycles; HALT=0 and DONE=1 two edges after the last accept; ADDRESS_BUS=0 and DATA_OE=0 in RUN.
REQ-036 Mismatch: same image with EXPECTED_SUM=0x0007 -> FAULT, ERROR=1, HALT stays 1; a second START with a correct sum -> RUN.
REQ-037 Wrap and backpressure: base=0xFFFF len=2, IN_VALID low for 2 cycles between words -> writes at 0xFFFF then 0x0000, MEM_WE=0 during the gap.
REQ-038 Zero length: START len=0 sum=0 -> RUN two edges later with no MEM_WE pulse; with sum=0x0001 -> FAULT.
REQ-039 Reset mid-load: RESET asserted after 1 of 3 words -> all outputs at their reset values asynchronously and no further writes; START held during LOAD -> no effect.
REQ-040 Reload: START while in RUN -> HALT=1 and DONE=0 on the next edge, then a new image loads normally.
